// File: rtl/aud_i2s_tx.sv
// aud_i2s_tx: stereo I2S / left-justified DAC serializer with a frame FIFO.
// The whole block runs on BCLK. LRCK edges drive slot starts; left starts pop
// a frame, and right starts replay the right sample held from that pop.
module aud_i2s_tx #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int MODE   = 0
) (
   input  logic                   i_bclk,
   input  logic                   i_rst_n,
   input  logic                   i_daclrck,
   input  logic                   i_en,
   input  logic                   i_valid,
   input  logic [DATA_W-1:0]      i_left,
   input  logic [DATA_W-1:0]      i_right,
   output logic                   o_ready,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_aud_dacdat,
   output logic                   o_underrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DATA_W + 1);

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } frame_t;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT} state_t;

   frame_t            r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr, r_rd_ptr;
   logic              r_lrck_prev, r_lrck_vld;
   logic [DATA_W-1:0] r_shift, r_hold;
   logic [CW-1:0]     r_cnt;
   state_t            r_state;
   logic              r_dacdat, r_underrun;

   logic [AW:0]       w_level;
   logic              w_empty, w_full, w_push, w_pop;
   logic              w_edge, w_left_start, w_right_start;
   logic [DATA_W-1:0] w_word;
   frame_t            w_head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_level       = r_wr_ptr - r_rd_ptr;
   assign w_empty       = (w_level == '0);
   assign w_full        = (w_level == (AW+1)'(DEPTH));
   assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
   // Edge detection is suppressed until LRCK has been captured once after reset.
   assign w_edge        = r_lrck_vld && (i_daclrck != r_lrck_prev);
   assign w_left_start  = w_edge && !i_daclrck;
   assign w_right_start = w_edge && i_daclrck;
   assign w_push        = i_valid && !w_full;
   // Pop looks at the registered level, so a same-cycle push is never bypassed.
   assign w_pop         = w_left_start && i_en && !w_empty;

   assign o_ready      = !w_full;
   assign o_level      = w_level;
   assign o_aud_dacdat = r_dacdat;
   assign o_underrun   = r_underrun;

   // Word to start shifting at a slot edge; zeros for underrun, disabled or pre-left.
   always_comb begin
      w_word = '0;
      if (w_left_start)
         w_word = w_pop ? w_head.left : '0;
      else if (w_right_start)
         w_word = r_hold;
   end

   // Frame storage; no reset needed since occupancy is tracked by the pointers.
   always_ff @(posedge i_bclk) begin
      if (w_push)
         r_mem[r_wr_ptr[AW-1:0]] <= {i_left, i_right};
   end

   // FIFO pointer update; push and pop may both happen in one cycle.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Slot FSM and serializer; a new LRCK edge always preempts the word in flight.
   // r_hold resets to zero and is only written at left starts, so a right slot
   // before any left slot naturally sends zeros.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_hold      <= '0;
         r_cnt       <= '0;
         r_dacdat    <= 1'b0;
         r_underrun  <= 1'b0;
         r_lrck_prev <= 1'b0;
         r_lrck_vld  <= 1'b0;
      end else begin
         r_lrck_prev <= i_daclrck;
         r_lrck_vld  <= 1'b1;
         r_underrun  <= w_left_start && i_en && w_empty;
         if (w_left_start)
            r_hold <= w_pop ? w_head.right : '0;
         if (w_edge) begin
            if (MODE == 1) begin
               // Left-justified: MSB goes out on the edge cycle itself.
               r_dacdat <= w_word[DATA_W-1];
               r_shift  <= w_word << 1;
               r_cnt    <= CW'(1);
               r_state  <= S_SHIFT;
            end else begin
               // I2S: one idle bit after the edge before the MSB.
               r_dacdat <= 1'b0;
               r_shift  <= w_word;
               r_cnt    <= '0;
               r_state  <= S_DELAY;
            end
         end else begin
            case (r_state)
               S_DELAY, S_SHIFT: begin
                  if (r_cnt == CW'(DATA_W)) begin
                     r_dacdat <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_dacdat <= r_shift[DATA_W-1];
                     r_shift  <= r_shift << 1;
                     r_cnt    <= r_cnt + 1'b1;
                     r_state  <= S_SHIFT;
                  end
               end
               default: begin
                  r_dacdat <= 1'b0;
                  r_state  <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule
